// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller and its load-word assembler.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam logic [15:0] HALT_INSN = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'd2;
  localparam int          IMEM_AW   = 4;

endpackage

// File: rtl/load_word_assembler.sv
// Byte-serial to word assembler: high byte first, strobes when the low byte completes a word.
import fetch_pkg::*;

module load_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        phase,
  output logic        word_done,
  output logic [15:0] word
);

  logic [7:0] hi_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (byte_valid) begin
      phase <= ~phase;
    end
  end

  // High-byte latch is pure data; phase alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (byte_valid && !phase) begin
      hi_byte <= byte_in;
    end
  end

  assign word_done = byte_valid & phase & ~clear;
  assign word      = {hi_byte, byte_in};

endmodule

// File: rtl/fetch_controller.sv
// PC sequencer and instruction-memory program loader under one FSM.
// Optional macro FETCH_CTRL_ALIGN_CHECK_EN: odd branch targets halt the core and set misalign.
import fetch_pkg::*;

module fetch_controller #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run_start,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [7:0]   load_byte,
  output logic         load_ready,
  input  logic         load_end,
  input  logic [15:0]  instruction,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [15:0]  branch_target,
  output logic [15:0]  pc,
  output logic         imem_we,
  output logic [3:0]   imem_waddr,
  output logic [15:0]  imem_wdata,
  output logic         running,
  output logic         halted,
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  output logic         misalign,
`endif
  output logic         load_err
);

  localparam logic [IMEM_AW-1:0] CNT_LAST = IMEM_AW'(IMEM_DEPTH - 1);

  fetch_state_t       state, state_nxt;
  logic [IMEM_AW-1:0] count;
  logic [15:0]        pc_nxt;
  logic               err_nxt;
  logic               asm_clear;
  logic               byte_accept;
  logic               phase;
  logic               word_done;
  logic [15:0]        word;
  logic               idle_like;
  logic               bad_target;
  logic               is_halt_insn;

  assign idle_like    = (state == ST_IDLE) || (state == ST_HALT);
  assign is_halt_insn = (instruction == HALT_INSN);
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  assign bad_target   = branch_target[0];
`else
  assign bad_target   = 1'b0;
`endif

  load_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .byte_valid (byte_accept),
    .byte_in    (load_byte),
    .phase      (phase),
    .word_done  (word_done),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (load_start)     state_nxt = ST_LOAD;
        else if (run_start) state_nxt = ST_RUN;
      end
      ST_LOAD: begin
        if (load_end)                              state_nxt = ST_IDLE;
        else if (word_done && (count == CNT_LAST)) state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (is_halt_insn)                    state_nxt = ST_HALT;
        else if (!stall && branch_taken && bad_target) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: load_ready is combinational, the rest feed the output registers.
  always_comb begin
    load_ready  = (state == ST_LOAD);
    byte_accept = (state == ST_LOAD) && load_valid && !load_end;
    asm_clear   = (idle_like && load_start) || ((state == ST_LOAD) && load_end);
    pc_nxt      = pc;
    err_nxt     = load_err;
    if (idle_like && load_start) begin
      err_nxt = 1'b0;
    end else if (idle_like && run_start) begin
      pc_nxt = RESET_PC;
    end
    if ((state == ST_LOAD) && load_end && phase) begin
      err_nxt = 1'b1;
    end
    if ((state == ST_RUN) && !is_halt_insn && !stall) begin
      if (branch_taken) begin
        if (!bad_target) pc_nxt = branch_target & 16'hFFFE;
      end else begin
        pc_nxt = pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      count      <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      imem_we  <= word_done;
      running  <= (state_nxt == ST_RUN);
      halted   <= (state_nxt == ST_HALT);
      load_err <= err_nxt;
      if (word_done) begin
        imem_waddr <= count;
        imem_wdata <= word;
        count      <= count + 1'b1;
      end else if (asm_clear) begin
        count <= '0;
      end
    end
  end

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (idle_like && !load_start && run_start) begin
      misalign <= 1'b0;
    end else if ((state == ST_RUN) && !is_halt_insn && !stall && branch_taken && bad_target) begin
      misalign <= 1'b1;
    end
  end
`endif

endmodule
